// File: rtl/pipe_stage_skid_reg_pkg.sv
// Shared definitions for the generic pipeline-stage register: occupancy
// encodings, default payload widths per stage boundary and a small helper.
package pipe_stage_skid_reg_pkg;

    // Number of entries held by a stage, doubling as the control state.
    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_e;

    // Default payload widths for each CPU stage boundary.
    localparam int IF_ID_W  = 96;
    localparam int ID_EX_W  = 160;
    localparam int EX_MEM_W = 128;
    localparam int MEM_WB_W = 96;

    // Number of held entries from the two entry valid bits.
    function automatic logic [1:0] occCount(input logic mValid, input logic sValid);
        return {1'b0, mValid} + {1'b0, sValid};
    endfunction

endpackage

// File: rtl/pipe_stage_skid_reg_payload.sv
// One pipeline entry: a valid bit plus its payload register, with
// load / clear / hold controls. Clear drops the entry and, when
// ZERO_ON_BUBBLE is set, also wipes the payload so empty slots read as 0.
module pipe_payload_reg #(
    parameter int DATA_W         = 160,
    parameter bit ZERO_ON_BUBBLE = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic              i_clear,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data
);

    logic              r_valid;
    logic [DATA_W-1:0] r_data;

    // Entry update: reset wipes everything, clear wins over load, otherwise hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_clear) begin
            r_valid <= 1'b0;
            if (ZERO_ON_BUBBLE) begin
                r_data <= '0;
            end
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule

// File: rtl/pipe_stage_skid_reg.sv
// Generic pipeline-stage register with valid/ready handshake, optional
// two-entry skid buffer, flush, bubble insertion and global freeze.
// The head entry M always drives out_data; S only exists when SKID=1 and
// catches the word accepted while the downstream is stalled, which keeps
// in_ready free of any combinational path from out_ready.
module pipe_stage_skid_reg
    import pipe_stage_skid_reg_pkg::*;
#(
    parameter int DATA_W         = 160,
    parameter bit SKID           = 1'b1,
    parameter bit ZERO_ON_BUBBLE = 1'b1,
    parameter int CNT_W          = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_en,
    input  logic              flush,
    input  logic              in_valid,
    input  logic              in_bubble,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  bubble_count
);

    logic              w_mValid;
    logic [DATA_W-1:0] w_mData;
    logic              w_sValid;
    logic [DATA_W-1:0] w_sData;

    logic              w_inReady;
    logic              w_outValid;
    logic              w_accept;
    logic              w_pop;
    occ_e              w_occState;

    logic              w_mLoad;
    logic              w_mClear;
    logic [DATA_W-1:0] w_mDin;
    logic              w_sLoad;
    logic              w_sClear;

    logic [CNT_W-1:0]  r_bubbleCount;

    // Head entry, always present.
    pipe_payload_reg #(
        .DATA_W         (DATA_W),
        .ZERO_ON_BUBBLE (ZERO_ON_BUBBLE)
    ) uMain (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_mLoad),
        .i_clear (w_mClear),
        .i_data  (w_mDin),
        .o_valid (w_mValid),
        .o_data  (w_mData)
    );

    // Skid entry, only built when the stage is configured for two entries.
    generate
        if (SKID) begin : genSkid
            pipe_payload_reg #(
                .DATA_W         (DATA_W),
                .ZERO_ON_BUBBLE (ZERO_ON_BUBBLE)
            ) uSkid (
                .clk     (clk),
                .rst     (rst),
                .i_load  (w_sLoad),
                .i_clear (w_sClear),
                .i_data  (in_data),
                .o_valid (w_sValid),
                .o_data  (w_sData)
            );
        end else begin : genNoSkid
            assign w_sValid = 1'b0;
            assign w_sData  = '0;
        end
    endgenerate

    // Handshake qualifiers; a frozen stage neither offers nor accepts data.
    always_comb begin
        w_occState = occ_e'(occCount(w_mValid, w_sValid));
        if (SKID) begin
            w_inReady = cpu_en & ~w_sValid;
        end else begin
            w_inReady = cpu_en & (~w_mValid | out_ready);
        end
        w_outValid = w_mValid & cpu_en;
        w_accept   = cpu_en & in_valid & w_inReady & ~in_bubble & ~flush;
        w_pop      = w_outValid & out_ready;
    end

    // Entry control: decide per occupancy which entry loads, shifts or empties.
    // Flush empties both entries; a pop in the same cycle has already been
    // sampled downstream, so dropping M is the correct outcome.
    always_comb begin
        w_mLoad  = 1'b0;
        w_mClear = 1'b0;
        w_mDin   = in_data;
        w_sLoad  = 1'b0;
        w_sClear = 1'b0;
        if (cpu_en) begin
            if (flush) begin
                w_mClear = 1'b1;
                w_sClear = 1'b1;
            end else begin
                case (w_occState)
                    OCC_EMPTY: begin
                        if (w_accept) begin
                            w_mLoad = 1'b1;
                        end
                    end
                    OCC_ONE: begin
                        if (w_accept && w_pop) begin
                            w_mLoad = 1'b1;
                        end else if (w_accept) begin
                            w_sLoad = 1'b1;
                        end else if (w_pop) begin
                            w_mClear = 1'b1;
                        end
                    end
                    OCC_FULL: begin
                        if (w_pop) begin
                            w_mLoad  = 1'b1;
                            w_mDin   = w_sData;
                            w_sClear = 1'b1;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    // Saturating count of cycles in which upstream asked for a bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bubbleCount <= '0;
        end else if (cpu_en && !flush && in_bubble && (r_bubbleCount != {CNT_W{1'b1}})) begin
            r_bubbleCount <= r_bubbleCount + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign in_ready     = w_inReady;
    assign out_valid    = w_outValid;
    assign out_data     = w_mData;
    assign occupancy    = occCount(w_mValid, w_sValid);
    assign bubble_count = r_bubbleCount;

endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// Directed bench for pipe_stage_skid_reg: a default skid instance, a
// 3-bit-counter instance for saturation and a SKID=0 instance.
module tb_pipe_stage_skid_reg;

    localparam int DW = 160;

    logic          clk = 1'b0;
    logic          rst;
    logic          cpuEn;
    logic          flush;
    logic          inValid;
    logic          inBubble;
    logic [DW-1:0] inData;
    logic          inReady;
    logic          outValid;
    logic          outReady;
    logic [DW-1:0] outData;
    logic [1:0]    occupancy;
    logic [15:0]   bubbleCount;

    logic          b3;
    logic          s3InReady;
    logic          s3OutValid;
    logic [DW-1:0] s3OutData;
    logic [1:0]    s3Occ;
    logic [2:0]    bubbleCount3;

    logic          nsInValid;
    logic [DW-1:0] nsInData;
    logic          nsOutReady;
    logic          nsInReady;
    logic          nsOutValid;
    logic [DW-1:0] nsOutData;
    logic [1:0]    nsOcc;
    logic [15:0]   nsBubble;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    pipe_stage_skid_reg dut (
        .clk(clk), .rst(rst), .cpu_en(cpuEn), .flush(flush),
        .in_valid(inValid), .in_bubble(inBubble), .in_data(inData),
        .in_ready(inReady), .out_valid(outValid), .out_ready(outReady),
        .out_data(outData), .occupancy(occupancy), .bubble_count(bubbleCount)
    );

    pipe_stage_skid_reg #(.CNT_W(3)) dut3 (
        .clk(clk), .rst(rst), .cpu_en(cpuEn), .flush(flush),
        .in_valid(1'b0), .in_bubble(b3), .in_data({DW{1'b0}}),
        .in_ready(s3InReady), .out_valid(s3OutValid), .out_ready(1'b1),
        .out_data(s3OutData), .occupancy(s3Occ), .bubble_count(bubbleCount3)
    );

    pipe_stage_skid_reg #(.SKID(1'b0)) dutNs (
        .clk(clk), .rst(rst), .cpu_en(cpuEn), .flush(flush),
        .in_valid(nsInValid), .in_bubble(1'b0), .in_data(nsInData),
        .in_ready(nsInReady), .out_valid(nsOutValid), .out_ready(nsOutReady),
        .out_data(nsOutData), .occupancy(nsOcc), .bubble_count(nsBubble)
    );

    // A valid skid entry must always sit behind a valid head entry.
    always @(negedge clk) begin
        if (dut.genSkid.uSkid.o_valid === 1'b1 && dut.uMain.o_valid !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL invariant_s_implies_m: S valid=1 with M valid=%b, required M valid=1", dut.uMain.o_valid);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; cpuEn = 1'b1; flush = 1'b0; inValid = 1'b1; inBubble = 1'b0;
        inData = DW'(32'hA5); outReady = 1'b0; b3 = 1'b0;
        nsInValid = 1'b0; nsInData = '0; nsOutReady = 1'b0;
        for (int k = 0; k < 2; k++) begin
            step();
            vectors++;
            if (outValid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_out_valid: got %b want 0", outValid); end
            vectors++;
            if (outData !== '0) begin miscompares++; $display("[TB] FAIL reset_out_data: got %h want 0", outData); end
            vectors++;
            if (occupancy !== 2'd0) begin miscompares++; $display("[TB] FAIL reset_occ: got %0d want 0", occupancy); end
            vectors++;
            if (bubbleCount !== 16'd0) begin miscompares++; $display("[TB] FAIL reset_bubble: got %0d want 0", bubbleCount); end
            vectors++;
            if (inReady !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_in_ready: got %b want 1", inReady); end
        end
        rst = 1'b0; inValid = 1'b0;
    endtask

    task automatic test_stream();
        outReady = 1'b1;
        inValid = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            inData = DW'(i);
            #1;
            vectors++;
            if (inReady !== 1'b1) begin miscompares++; $display("[TB] FAIL stream_in_ready[%0d]: got %b want 1", i, inReady); end
            step();
            vectors++;
            if (outValid !== 1'b1 || outData !== DW'(i)) begin
                miscompares++;
                $display("[TB] FAIL stream_out[%0d]: got valid=%b data=%h want valid=1 data=%h", i, outValid, outData, DW'(i));
            end
        end
        inValid = 1'b0;
        step();
        vectors++;
        if (outValid !== 1'b0 || occupancy !== 2'd0 || outData !== '0) begin
            miscompares++;
            $display("[TB] FAIL stream_drain: got valid=%b occ=%0d data=%h want 0/0/0", outValid, occupancy, outData);
        end
    endtask

    task automatic test_backpressure();
        outReady = 1'b0; inValid = 1'b1; inData = DW'(8'h11);
        step();
        vectors++;
        if (occupancy !== 2'd1 || outData !== DW'(8'h11)) begin
            miscompares++; $display("[TB] FAIL bp_first: got occ=%0d data=%h want 1/11", occupancy, outData);
        end
        inData = DW'(8'h22);
        step();
        vectors++;
        if (occupancy !== 2'd2) begin miscompares++; $display("[TB] FAIL bp_occ2: got %0d want 2", occupancy); end
        vectors++;
        if (inReady !== 1'b0) begin miscompares++; $display("[TB] FAIL bp_in_ready: got %b want 0", inReady); end
        vectors++;
        if (outData !== DW'(8'h11)) begin miscompares++; $display("[TB] FAIL bp_head: got %h want 11", outData); end
        inValid = 1'b0; outReady = 1'b1;
        step();
        vectors++;
        if (occupancy !== 2'd1 || outData !== DW'(8'h22) || outValid !== 1'b1) begin
            miscompares++; $display("[TB] FAIL bp_second: got occ=%0d data=%h valid=%b want 1/22/1", occupancy, outData, outValid);
        end
        step();
        vectors++;
        if (occupancy !== 2'd0 || outValid !== 1'b0) begin
            miscompares++; $display("[TB] FAIL bp_empty: got occ=%0d valid=%b want 0/0", occupancy, outValid);
        end
    endtask

    task automatic test_flush();
        outReady = 1'b0; inValid = 1'b1; inData = DW'(8'h55);
        step();
        inData = DW'(8'h66);
        step();
        vectors++;
        if (occupancy !== 2'd2) begin miscompares++; $display("[TB] FAIL flush_fill: got %0d want 2", occupancy); end
        flush = 1'b1; outReady = 1'b1; inData = DW'(8'h33);
        step();
        flush = 1'b0; inValid = 1'b0;
        #1;
        vectors++;
        if (occupancy !== 2'd0 || outValid !== 1'b0 || outData !== '0) begin
            miscompares++; $display("[TB] FAIL flush_full: got occ=%0d valid=%b data=%h want 0/0/0", occupancy, outValid, outData);
        end
        // Flush with one entry and in_ready high must still drop the incoming word.
        outReady = 1'b0; inValid = 1'b1; inData = DW'(8'h77);
        step();
        flush = 1'b1; outReady = 1'b1; inData = DW'(8'h33);
        step();
        flush = 1'b0; inValid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            step();
            vectors++;
            if (occupancy !== 2'd0 || outValid !== 1'b0) begin
                miscompares++; $display("[TB] FAIL flush_drop[%0d]: got occ=%0d valid=%b data=%h want 0/0", k, occupancy, outValid, outData);
            end
        end
    endtask

    task automatic test_bubble();
        outReady = 1'b0; inValid = 1'b1; inData = DW'(8'h88);
        step();
        inBubble = 1'b1; outReady = 1'b1; inData = DW'(8'h99);
        for (int k = 1; k <= 5; k++) begin
            step();
            vectors++;
            if (occupancy !== 2'd0 || outValid !== 1'b0 || bubbleCount !== 16'(k)) begin
                miscompares++;
                $display("[TB] FAIL bubble[%0d]: got occ=%0d valid=%b count=%0d want 0/0/%0d", k, occupancy, outValid, bubbleCount, k);
            end
        end
        inBubble = 1'b0; inValid = 1'b0;
        b3 = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            step();
            vectors++;
            if (bubbleCount3 !== 3'((k > 7) ? 7 : k)) begin
                miscompares++;
                $display("[TB] FAIL bubble_sat[%0d]: got %0d want %0d", k, bubbleCount3, (k > 7) ? 7 : k);
            end
        end
        b3 = 1'b0;
    endtask

    task automatic test_noskid();
        nsOutReady = 1'b0; nsInValid = 1'b1; nsInData = DW'(8'hC1);
        #1;
        vectors++;
        if (nsInReady !== 1'b1) begin miscompares++; $display("[TB] FAIL ns_ready_empty: got %b want 1", nsInReady); end
        step();
        vectors++;
        if (nsOcc !== 2'd1 || nsOutData !== DW'(8'hC1) || nsInReady !== 1'b0) begin
            miscompares++; $display("[TB] FAIL ns_hold: got occ=%0d data=%h ready=%b want 1/c1/0", nsOcc, nsOutData, nsInReady);
        end
        nsOutReady = 1'b1; nsInData = DW'(8'hC2);
        #1;
        vectors++;
        if (nsInReady !== 1'b1) begin miscompares++; $display("[TB] FAIL ns_ready_pass: got %b want 1", nsInReady); end
        step();
        vectors++;
        if (nsOcc !== 2'd1 || nsOutData !== DW'(8'hC2)) begin
            miscompares++; $display("[TB] FAIL ns_replace: got occ=%0d data=%h want 1/c2", nsOcc, nsOutData);
        end
        nsInValid = 1'b0;
        step();
        vectors++;
        if (nsOcc !== 2'd0 || nsOutValid !== 1'b0 || nsOutData !== '0) begin
            miscompares++; $display("[TB] FAIL ns_empty: got occ=%0d valid=%b data=%h want 0/0/0", nsOcc, nsOutValid, nsOutData);
        end
    endtask

    task automatic test_cpu_en();
        outReady = 1'b0; inValid = 1'b1; inData = DW'(8'h44);
        step();
        cpuEn = 1'b0; outReady = 1'b1; inData = DW'(8'h45);
        for (int k = 0; k < 4; k++) begin
            inBubble = (k == 3);
            #1;
            vectors++;
            if (inReady !== 1'b0 || outValid !== 1'b0) begin
                miscompares++; $display("[TB] FAIL freeze_hs[%0d]: got ready=%b valid=%b want 0/0", k, inReady, outValid);
            end
            step();
            vectors++;
            if (occupancy !== 2'd1 || outData !== DW'(8'h44) || bubbleCount !== 16'd5) begin
                miscompares++;
                $display("[TB] FAIL freeze_state[%0d]: got occ=%0d data=%h count=%0d want 1/44/5", k, occupancy, outData, bubbleCount);
            end
        end
        inBubble = 1'b0; cpuEn = 1'b1; inValid = 1'b0;
        #1;
        vectors++;
        if (outValid !== 1'b1 || outData !== DW'(8'h44)) begin
            miscompares++; $display("[TB] FAIL unfreeze_out: got valid=%b data=%h want 1/44", outValid, outData);
        end
        step();
        vectors++;
        if (occupancy !== 2'd0) begin miscompares++; $display("[TB] FAIL unfreeze_pop: got %0d want 0", occupancy); end
        outReady = 1'b0; inValid = 1'b1; inData = DW'(8'h46);
        step();
        inValid = 1'b0; cpuEn = 1'b0; rst = 1'b1;
        step();
        vectors++;
        if (occupancy !== 2'd0 || bubbleCount !== 16'd0) begin
            miscompares++; $display("[TB] FAIL frozen_reset: got occ=%0d count=%0d want 0/0", occupancy, bubbleCount);
        end
        rst = 1'b0; cpuEn = 1'b1;
        #1;
        vectors++;
        if (outValid !== 1'b0 || outData !== '0 || inReady !== 1'b1) begin
            miscompares++; $display("[TB] FAIL post_reset: got valid=%b data=%h ready=%b want 0/0/1", outValid, outData, inReady);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_flush();
        test_bubble();
        test_noskid();
        test_cpu_en();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
